// File: rtl/ib_ram_page_loader_pkg.sv
// Shared definitions for the IB-RAM wrapper: loader FSM encoding and LUT page geometry.
package ib_ram_page_loader_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_LOAD = LOAD,
    S_FIN  = FIN
  } ldr_state_e;

  // Page index width is what remains of the RAM address after the frame-select MSBs.
  function automatic int calc_page_w(input int entry_addr, input int multi_frame_num);
    return entry_addr - $clog2(multi_frame_num);
  endfunction

  function automatic int calc_page_num(input int entry_addr, input int multi_frame_num);
    return 1 << calc_page_w(entry_addr, multi_frame_num);
  endfunction

endpackage

// File: rtl/ib_ram_page_loader.sv
// Loads one frame of LUT pages into the inactive multi-frame half of the IB-CNU LUT RAMs
// and counts completed loads (one per decoding iteration).
module ib_ram_page_loader
  import ib_ram_page_loader_pkg::*;
#(
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int BANK_NUM        = 2,
  parameter int LUT_PORT_SIZE   = 2,
  parameter int ITER_MAX        = 10,
  localparam int FRAME_W        = $clog2(MULTI_FRAME_NUM),
  localparam int DATA_W         = LUT_PORT_SIZE * BANK_NUM,
  localparam int ITER_W         = $clog2(ITER_MAX + 1)
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [FRAME_W-1:0]    frame_sel,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ENTRY_ADDR-1:0] page_addr_ram,
  output logic [DATA_W-1:0]     ram_write_data,
  output logic                  ib_ram_we,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_W-1:0]     iter_cnt
);

  localparam int PAGE_W   = calc_page_w(ENTRY_ADDR, MULTI_FRAME_NUM);
  localparam int PAGE_NUM = calc_page_num(ENTRY_ADDR, MULTI_FRAME_NUM);

  // Handshake: a beat transfers on any edge where in_valid && in_ready. in_ready is
  // purely a function of state, so the source may not wait for it to commit a beat.
  ldr_state_e               state_q, state_d;
  logic [PAGE_W-1:0]        page_cnt_q, page_cnt_d;
  logic [FRAME_W-1:0]       frame_q, frame_d;
  logic [ENTRY_ADDR-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     we_q, we_d;
  logic                     done_q, done_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic                     hs;

  assign in_ready = (state_q == S_LOAD);
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    page_cnt_d = page_cnt_q;
    frame_d    = frame_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    iter_d     = iter_q;
    // abort wins over everything, including a beat accepted in the same cycle.
    if (abort) begin
      state_d    = S_IDLE;
      page_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_LOAD;
            frame_d    = frame_sel;
            page_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            data_d     = in_data;
            addr_d     = {frame_q, page_cnt_q};
            we_d       = 1'b1;
            page_cnt_d = page_cnt_q + PAGE_W'(1);
            if (page_cnt_q == PAGE_W'(PAGE_NUM - 1)) begin
              state_d    = S_FIN;
              page_cnt_d = '0;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          iter_d  = (iter_q == ITER_W'(ITER_MAX - 1)) ? '0 : iter_q + ITER_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      page_cnt_q <= '0;
      frame_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      page_cnt_q <= page_cnt_d;
      frame_q    <= frame_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      iter_q     <= iter_d;
    end
  end

  assign page_addr_ram  = addr_q;
  assign ram_write_data = data_q;
  assign ib_ram_we      = we_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign iter_cnt       = iter_q;

endmodule

// File: tb/tb_ib_ram_page_loader.sv
// Directed bench for ib_ram_page_loader: write-port trace against an expected queue,
// plus cycle-exact checks on handshake, done and iteration count.
module tb_ib_ram_page_loader;

  logic       write_clk;
  logic       rstn;
  logic       start;
  logic [0:0] frame_sel;
  logic       abort;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] page_addr_ram;
  logic [3:0] ram_write_data;
  logic       ib_ram_we;
  logic       busy;
  logic       done;
  logic [3:0] iter_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_iter = 0;

  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];

  ib_ram_page_loader dut (
    .write_clk      (write_clk),
    .rstn           (rstn),
    .start          (start),
    .frame_sel      (frame_sel),
    .abort          (abort),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .page_addr_ram  (page_addr_ram),
    .ram_write_data (ram_write_data),
    .ib_ram_we      (ib_ram_we),
    .busy           (busy),
    .done           (done),
    .iter_cnt       (iter_cnt)
  );

  // clock / reset
  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // write-port monitor, sampled mid-cycle
  always @(negedge write_clk) begin
    if (ib_ram_we) wr_q.push_back({page_addr_ram, ram_write_data});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_we"}, 32'(ib_ram_we), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_iter"}, 32'(iter_cnt), 32'd0);
    chk({tag, "_addr"}, 32'(page_addr_ram), 32'd0);
    chk({tag, "_data"}, 32'(ram_write_data), 32'd0);
  endtask

  // scoreboard: compare the recorded write trace with the expected queue
  task automatic check_writes(input string tag);
    logic [7:0] e;
    logic [7:0] a;
    chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_q.pop_front();
      chk({tag, "_write"}, 32'(a), 32'(e));
    end
    exp_q.delete();
    wr_q.delete();
  endtask

  function automatic int next_iter(input int it);
    return (it == 9) ? 0 : it + 1;
  endfunction

  // driver: one full back-to-back load; optional stray start pulses in LOAD and FIN
  task automatic do_full_load(input logic fsel, input logic [3:0] key, input bit start_noise);
    frame_sel = fsel;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    for (int p = 0; p < 8; p++) begin
      in_data = 4'(p) ^ key;
      start = start_noise && (p == 4);
      exp_q.push_back({fsel, 3'(p), 4'(p) ^ key});
      tick();
      chk("load_we", 32'(ib_ram_we), 32'd1);
    end
    in_valid = 1'b0;
    start = start_noise;
    chk("load_fin_busy", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    exp_iter = next_iter(exp_iter);
    chk("load_done", 32'(done), 32'd1);
    chk("load_done_busy", 32'(busy), 32'd0);
    chk("load_iter", 32'(iter_cnt), 32'(exp_iter));
    tick();
    chk("load_done_clr", 32'(done), 32'd0);
    chk("load_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int p;
    int cyc;
    int d0;
    rstn = 1'b0;
    start = 1'b0;
    frame_sel = '0;
    abort = 1'b0;
    in_data = '0;
    in_valid = 1'b0;

    // reset state
    tick();
    tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // basic load into frame 1, data = page index
    frame_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'(i);
      exp_q.push_back({1'b1, 3'(i), 4'(i)});
      tick();
      chk("basic_we", 32'(ib_ram_we), 32'd1);
      chk("basic_addr", 32'(page_addr_ram), 32'(8 + i));
      chk("basic_data", 32'(ram_write_data), 32'(i));
    end
    in_valid = 1'b0;
    chk("basic_fin_busy", 32'(busy), 32'd1);
    tick();
    exp_iter = 1;
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy_clr", 32'(busy), 32'd0);
    chk("basic_iter", 32'(iter_cnt), 32'd1);
    chk("basic_we_clr", 32'(ib_ram_we), 32'd0);
    tick();
    check_writes("basic");

    // stalls: valid on every third cycle, frame 0
    frame_sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    p = 0;
    cyc = 0;
    while (p < 8 && cyc < 100) begin
      in_valid = (cyc % 3 == 0);
      in_data = 4'(15 - p);
      if (in_valid) exp_q.push_back({1'b0, 3'(p), 4'(15 - p)});
      tick();
      chk("stall_we", 32'(ib_ram_we), 32'(in_valid));
      if (in_valid) begin
        chk("stall_addr", 32'(page_addr_ram), 32'(p));
        p++;
      end
      cyc++;
    end
    chk("stall_bound", 32'(p), 32'd8);
    in_valid = 1'b0;
    tick();
    exp_iter = 2;
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_iter", 32'(iter_cnt), 32'd2);
    tick();
    check_writes("stall");

    // abort coinciding with the 4th handshake
    d0 = done_cnt;
    frame_sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 4'(i) ^ 4'h5;
      exp_q.push_back({1'b0, 3'(i), 4'(i) ^ 4'h5});
      tick();
    end
    in_data = 4'h3 ^ 4'h5;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_we", 32'(ib_ram_we), 32'd0);
    tick();
    tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_iter", 32'(iter_cnt), 32'd2);
    check_writes("abort");
    do_full_load(1'b1, 4'hA, 1'b0);
    check_writes("after_abort");

    // stray start pulses during LOAD and FIN
    d0 = done_cnt;
    do_full_load(1'b0, 4'h3, 1'b1);
    tick();
    chk("noise_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("noise_idle", 32'(busy), 32'd0);
    check_writes("noise");

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_ready", 32'(in_ready), 32'd0);
    tick();
    chk("start_abort_idle", 32'(busy), 32'd0);

    // reset at page 5
    frame_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(i + 2);
      exp_q.push_back({1'b1, 3'(i), 4'(i + 2)});
      tick();
    end
    in_data = 4'h7;
    rstn = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midreset_no_we", 32'(ib_ram_we), 32'd0);
      chk("midreset_no_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check_writes("midreset");
    exp_iter = 0;

    // ten back-to-back loads: iter_cnt 1..9 then 0
    for (int n = 0; n < 10; n++) begin
      do_full_load(1'(n), 4'(n), 1'b0);
    end
    chk("wrap_iter", 32'(iter_cnt), 32'd0);
    tick();
    check_writes("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ib_ram_page_loader.md
# ib_ram_page_loader

Iteration-update loader for the symmetric IB-CNU LUT RAMs (`sym_cn_lut_internal` instances in the CNU6 f1/f2/f3 sub-datapaths). On each start request it accepts one full frame of LUT pages from a valid/ready source and drives the RAM write port: `page_addr_ram`, `ram_write_data`, `ib_ram_we`. Writes go to the multi-frame half selected at start, so the decoder keeps reading the other half via `read_addr_offset` (double buffering). It also counts completed loads, one per decoding iteration.

## Interface
Parameters:
- ENTRY_ADDR, 4, RAM page address width including the frame-select MSBs
- MULTI_FRAME_NUM, 2, number of multi-frame halves; FRAME_W = $clog2(MULTI_FRAME_NUM)
- BANK_NUM, 2, banks per page
- LUT_PORT_SIZE, 2, bits per bank per page
- ITER_MAX, 10, iteration counter wrap value

Derived: PAGE_W = ENTRY_ADDR-FRAME_W; PAGE_NUM = 2**PAGE_W (8 by default); DATA_W = LUT_PORT_SIZE*BANK_NUM.

Ports:
- write_clk  in  1  sole clock
- rstn  in  1  reset; synchronous, active-low
- start  in  1  load request, single-cycle pulse
- frame_sel  in  FRAME_W  target half, sampled with start
- abort  in  1  cancel the current load
- in_data  in  DATA_W  page word, bank0 in the MSBs
- in_valid  in  1  source data valid
- in_ready  out  1  loader accepts the beat
- page_addr_ram  out  ENTRY_ADDR  {frame, page}
- ram_write_data  out  DATA_W  registered in_data
- ib_ram_we  out  1  write strobe
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- iter_cnt  out  $clog2(ITER_MAX+1)  completed loads, modulo ITER_MAX

## Operation
- FSM states: IDLE, LOAD, FIN.
  - IDLE to LOAD on start & !abort. The same edge latches frame_sel and clears page_cnt to 0.
  - LOAD to FIN on the handshake with page_cnt==PAGE_NUM-1.
  - FIN to IDLE unconditionally.
- in_ready = (state==LOAD). This is combinational from state, with no dependency on in_valid.
- Handshake is in_valid & in_ready. Each handshake:
  - registers in_data into ram_write_data;
  - registers {frame_q, page_cnt} into page_addr_ram;
  - sets ib_ram_we=1 for the next cycle;
  - increments page_cnt.
- Without a handshake, ib_ram_we=0. The address and data registers hold their last values.
- Pages are written strictly in order 0..PAGE_NUM-1. page_cnt never wraps inside one load.
- On FIN: done=1 in the following cycle, and iter_cnt increments, wrapping ITER_MAX-1 to 0.
- start while busy is ignored. start during FIN is ignored.
- abort (any state) forces IDLE on the next edge:
  - ib_ram_we=0 next cycle, no done, iter_cnt unchanged, page_cnt cleared;
  - a handshake in the abort cycle is discarded, since in_ready is already high, so the source must drop that beat.
  - abort beats start in the same cycle.
- busy = (state != IDLE).

## Timing
- Reset (rstn=0 at an edge): state=IDLE, page_cnt=0, frame_q=0, page_addr_ram=0, ram_write_data=0, ib_ram_we=0, done=0, iter_cnt=0, in_ready=0, busy=0. Reset mid-load behaves as abort and also clears iter_cnt.
- start at cycle 0 gives busy=1 and in_ready=1 from cycle 1.
- Write latency: a handshake at cycle k gives ib_ram_we=1 with matching address/data at cycle k+1.
- The last handshake at cycle k gives the last write at k+1 (state FIN, busy=1), then done=1, busy=0 and the updated iter_cnt at k+2.
- Throughput is one page per cycle with in_valid held high. A minimum load is PAGE_NUM+2 cycles from start to done.
- Gaps in in_valid stall with ib_ram_we=0. No timeout.

## Structure
- Shared package, with the rest of the IB-RAM wrapper:
  - FSM state encoding localparams (IDLE=2'd0, LOAD=2'd1, FIN=2'd2);
  - the PAGE_NUM/PAGE_W derivation.
- Single module, no sub-modules. The iteration counter stays inline; it does not justify a separate instance.

## Test plan
- Basic load, defaults: start with frame_sel=1, then 8 beats of in_data=page index with in_valid high. Required: ib_ram_we high for 8 consecutive cycles, page_addr_ram 0x8..0xF, data 0..7, done one cycle after the last write, iter_cnt=1.
- Stalls: in_valid toggled 1,0,0,1,… over the frame with frame_sel=0. Required: writes only on cycles following handshakes, addresses 0x0..0x7 in order, no duplicated or skipped pages.
- Abort after 3 beats, with abort coinciding with the 4th handshake. Required: only pages 0..2 written, no done, iter_cnt unchanged, busy=0 next cycle. A following start performs a full 8-page load from page 0.
- start pulses during LOAD and FIN are ignored: exactly 8 writes, one done. start and abort together in IDLE: no load.
- Iteration wrap: 10 back-to-back loads with ITER_MAX=10. Required: iter_cnt runs 1..9 then 0.
- rstn=0 for one cycle at page 5. Required: all outputs return to the reset values listed in Timing on the next cycle; no writes until the next start.
